periph_bridge: RTL and testbench



---
 rtl/periph_bridge_pkg.sv | 10 +
 rtl/periph_lane_align.sv | 26 ++
 rtl/periph_bridge.sv | 101 ++++++++++
 tb/tb_periph_bridge.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/periph_bridge_pkg.sv
// periph_bridge_pkg: size encodings, FSM states and alignment check for the peripheral bridge
package periph_bridge_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RSP} state_t;
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_HALF) ? off[0] : (size == SZ_WORD) ? |off : (size != SZ_BYTE);
  endfunction
endpackage

// File: rtl/periph_lane_align.sv
// periph_lane_align: little-endian lane extract/extend for loads, lane shift and merge for stores
module periph_lane_align
  import periph_bridge_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word,
  output logic [31:0] st_merge
);
  logic [4:0]  sh;
  logic [31:0] rd_sh, mask, lane_mask;
  assign sh = {off, 3'b000};
  always_comb begin
    rd_sh     = rd_word >> sh;
    mask      = (size == SZ_BYTE) ? 32'h0000_00ff : (size == SZ_HALF) ? 32'h0000_ffff : 32'hffff_ffff;
    lane_mask = mask << sh;
    ld_data   = (size == SZ_BYTE) ? {{24{~is_unsigned & rd_sh[7]}}, rd_sh[7:0]} :
                (size == SZ_HALF) ? {{16{~is_unsigned & rd_sh[15]}}, rd_sh[15:0]} : rd_sh;
    st_word   = (wdata & mask) << sh;
    st_merge  = (rd_word & ~lane_mask) | st_word;
  end
endmodule

// File: rtl/periph_bridge.sv
// periph_bridge: CPU load/store port to word-wide peripheral bus, with read-modify-write for sub-word stores
module periph_bridge
  import periph_bridge_pkg::*;
#(
  parameter int RMW_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [13:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [13:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [31:0] bus_read_data
);
  state_t      state, nxt;
  logic [1:0]  size_q, off_q, l_size, l_off;
  logic        uns_q, we_q, err_q, l_uns, accept, req_err;
  logic [31:0] wdata_q, rdata_q, l_wdata, ld_data, st_word, st_merge;

  assign req_ready = state == S_IDLE;
  assign bus_re    = state == S_RD;
  assign bus_we    = state == S_WR;
  assign rsp_valid = state == S_RSP;
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign accept    = req_valid & req_ready;
  assign req_err   = is_misaligned(req_size, req_addr[1:0]);

  // While idle the lane unit sees the live request so a direct write word is ready at accept
  assign l_size  = req_ready ? req_size : size_q;
  assign l_off   = req_ready ? req_addr[1:0] : off_q;
  assign l_uns   = req_ready ? req_unsigned : uns_q;
  assign l_wdata = req_ready ? req_wdata : wdata_q;

  periph_lane_align u_align (
    .size       (l_size),
    .off        (l_off),
    .is_unsigned(l_uns),
    .rd_word    (bus_read_data),
    .wdata      (l_wdata),
    .ld_data    (ld_data),
    .st_word    (st_word),
    .st_merge   (st_merge)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (accept) nxt = req_err ? S_RSP :
                                (!req_we || (RMW_EN != 0 && req_size != SZ_WORD)) ? S_RD : S_WR;
      S_RD:   nxt = S_CAP;
      S_CAP:  nxt = we_q ? S_WR : S_RSP;
      S_WR:   nxt = S_RSP;
      S_RSP:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      size_q         <= '0;
      off_q          <= '0;
      uns_q          <= 1'b0;
      we_q           <= 1'b0;
      err_q          <= 1'b0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      bus_address    <= '0;
      bus_write_data <= '0;
    end else begin
      if (accept) begin
        size_q  <= req_size;
        off_q   <= req_addr[1:0];
        uns_q   <= req_unsigned;
        we_q    <= req_we;
        err_q   <= req_err;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        if (!req_err) bus_address <= {req_addr[13:2], 2'b00};
        if (req_we && !req_err) bus_write_data <= st_word;
      end
      if (state == S_CAP) begin
        if (we_q) bus_write_data <= st_merge;
        else rdata_q <= ld_data;
      end
    end
endmodule

// File: tb/tb_periph_bridge.sv
// tb_periph_bridge: directed checks of loads, RMW and plain stores, errors and mid-access reset
module tb_periph_bridge;
  logic        clk = 1'b0, rst_n;
  logic        req_valid, req_we, req_unsigned;
  logic [13:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata, bus_read_data;
  logic        a_ready, a_rv, a_err, a_bwe, a_bre;
  logic [31:0] a_rdata, a_bwd;
  logic [13:0] a_badr;
  logic        b_ready, b_rv, b_err, b_bwe, b_bre;
  logic [31:0] b_rdata, b_bwd;
  logic [13:0] b_badr;
  int total = 0, bad = 0;
  logic        c_are[1:6], c_awe[1:6], c_arv[1:6], c_aerr[1:6], c_bre[1:6], c_bwe[1:6], c_brv[1:6];
  logic [31:0] c_ard[1:6], c_awd[1:6], c_bwd[1:6];
  logic [13:0] c_aad[1:6];

  always #5 clk = ~clk;

  periph_bridge #(.RMW_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(a_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(a_rv), .rsp_rdata(a_rdata), .rsp_err(a_err), .bus_address(a_badr),
    .bus_write_data(a_bwd), .bus_we(a_bwe), .bus_re(a_bre), .bus_read_data(bus_read_data)
  );

  periph_bridge #(.RMW_EN(0)) u_dut_nr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(b_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(b_rv), .rsp_rdata(b_rdata), .rsp_err(b_err), .bus_address(b_badr),
    .bus_write_data(b_bwd), .bus_we(b_bwe), .bus_re(b_bre), .bus_read_data(bus_read_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access; c_*[k] hold what both bridges show in cycle A+k
  task automatic access(input logic we, input logic [13:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      c_are[k] = a_bre; c_awe[k] = a_bwe; c_arv[k] = a_rv; c_aerr[k] = a_err;
      c_ard[k] = a_rdata; c_awd[k] = a_bwd; c_aad[k] = a_badr;
      c_bre[k] = b_bre; c_bwe[k] = b_bwe; c_brv[k] = b_rv; c_bwd[k] = b_bwd;
    end
  endtask

  function automatic int strobes_a();
    int n = 0;
    for (int k = 1; k <= 6; k++) n += int'(c_are[k]) + int'(c_awe[k]);
    return n;
  endfunction

  function automatic int strobes_b();
    int n = 0;
    for (int k = 1; k <= 6; k++) n += int'(c_bre[k]) + int'(c_bwe[k]);
    return n;
  endfunction

  initial begin
    int rv_seen;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; bus_read_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(a_ready), 32'h1);
    chk("rst_outs", {a_rv, a_err, a_bwe, a_bre, b_rv, b_bwe, b_bre}, 32'h0);
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_wdata", a_bwd, 32'h0);
    chk("rst_addr", 32'(a_badr), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {a_ready, b_ready}, 32'h3);

    bus_read_data = 32'hdead_beef;
    access(1'b0, 14'h0204, 2'b10, 1'b0, 32'h0);
    chk("wl_re1", 32'(c_are[1]), 32'h1);
    chk("wl_addr1", 32'(c_aad[1]), 32'h0204);
    chk("wl_re2", 32'(c_are[2]), 32'h0);
    chk("wl_rv2", 32'(c_arv[2]), 32'h0);
    chk("wl_rv3", 32'(c_arv[3]), 32'h1);
    chk("wl_rd3", c_ard[3], 32'hdead_beef);
    chk("wl_rv4", 32'(c_arv[4]), 32'h0);
    chk("wl_nr_rd", 32'(c_brv[3]), 32'h1);

    bus_read_data = 32'h80ff_0000;
    access(1'b0, 14'h0203, 2'b00, 1'b0, 32'h0);
    chk("bl_signed", c_ard[3], 32'hffff_ff80);
    access(1'b0, 14'h0203, 2'b00, 1'b1, 32'h0);
    chk("bl_unsigned", c_ard[3], 32'h0000_0080);
    access(1'b0, 14'h0202, 2'b01, 1'b0, 32'h0);
    chk("hl_signed", c_ard[3], 32'hffff_80ff);

    bus_read_data = 32'h1122_3344;
    access(1'b1, 14'h0802, 2'b01, 1'b0, 32'h0000_abcd);
    chk("hs_re1", 32'(c_are[1]), 32'h1);
    chk("hs_we2", 32'(c_awe[2]), 32'h0);
    chk("hs_we3", 32'(c_awe[3]), 32'h1);
    chk("hs_wd3", c_awd[3], 32'habcd_3344);
    chk("hs_addr3", 32'(c_aad[3]), 32'h0800);
    chk("hs_rv4", 32'(c_arv[4]), 32'h1);
    chk("hs_rd4", c_ard[4], 32'h0);
    chk("hs_nr_we1", 32'(c_bwe[1]), 32'h1);
    chk("hs_nr_wd1", c_bwd[1], 32'habcd_0000);

    access(1'b1, 14'h0801, 2'b00, 1'b0, 32'hffff_ff5a);
    chk("bs_nr_we1", 32'(c_bwe[1]), 32'h1);
    chk("bs_nr_wd1", c_bwd[1], 32'h0000_5a00);
    chk("bs_nr_rv2", 32'(c_brv[2]), 32'h1);
    chk("bs_nr_strobes", 32'(strobes_b()), 32'h1);
    chk("bs_rmw_wd3", c_awd[3], 32'h1122_5a44);

    access(1'b1, 14'h0100, 2'b10, 1'b0, 32'hcafe_f00d);
    chk("ws_we1", 32'(c_awe[1]), 32'h1);
    chk("ws_wd1", c_awd[1], 32'hcafe_f00d);
    chk("ws_rv2", 32'(c_arv[2]), 32'h1);
    chk("ws_strobes", 32'(strobes_a()), 32'h1);

    bus_read_data = 32'h5555_aaaa;
    access(1'b0, 14'h0201, 2'b10, 1'b0, 32'h0);
    chk("ew_rv_err1", {c_arv[1], c_aerr[1]}, 32'h3);
    chk("ew_rd1", c_ard[1], 32'h0);
    chk("ew_strobes", 32'(strobes_a() + strobes_b()), 32'h0);
    access(1'b0, 14'h0203, 2'b01, 1'b0, 32'h0);
    chk("eh_rv_err1", {c_arv[1], c_aerr[1]}, 32'h3);
    chk("eh_rd1", c_ard[1], 32'h0);
    chk("eh_strobes", 32'(strobes_a() + strobes_b()), 32'h0);
    access(1'b1, 14'h0200, 2'b11, 1'b0, 32'h1);
    chk("er_rv_err1", {c_arv[1], c_aerr[1], c_brv[1], c_berr_dummy()}, 32'he);

    bus_read_data = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h0204; req_size = 2'b10; req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mr_re1", 32'(a_bre), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("mr_re_drop", {a_bre, b_bre}, 32'h0);
    rv_seen = 0;
    repeat (2) begin
      @(negedge clk);
      rv_seen += int'(a_rv) + int'(b_rv);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      rv_seen += int'(a_rv) + int'(b_rv);
    end
    chk("mr_no_rsp", 32'(rv_seen), 32'h0);
    chk("mr_ready", {a_ready, b_ready}, 32'h3);
    access(1'b0, 14'h0204, 2'b10, 1'b0, 32'h0);
    chk("mr_next_rv3", 32'(c_arv[3]), 32'h1);
    chk("mr_next_rd3", c_ard[3], 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic c_berr_dummy();
    return b_err;
  endfunction
endmodule
